// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - MIPS fetch sequencer: owns the PC, drives imem requests and the decode handoff
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FLUSH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pending;
    logic [31:0] pc_inc;
    logic [31:0] br_target;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        redirect;
    logic        ack;

    assign pc_inc     = pc + 32'd4;
    assign redirect   = jmp | br_taken;
    assign br_target  = br_base + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign raw_target = jmp ? jmp_target : br_target;
    assign target     = {raw_target[31:2], 2'b00};
    // An ack only means something while a request is actually outstanding.
    assign ack        = imem_req & imem_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pending      <= 32'd0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= 32'd0;
            if_pc        <= 32'd0;
            if_pcplus4   <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            if (redirect && (raw_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= target;
                        imem_addr <= target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        // A request that has not completed cannot be withdrawn; park the target.
                        if (ack) begin
                            pc        <= target;
                            imem_addr <= target;
                        end else begin
                            pending <= target;
                            state   <= FLUSH;
                        end
                    end else if (ack) begin
                        if_instr   <= imem_rdata;
                        if_pc      <= pc;
                        if_pcplus4 <= pc_inc;
                        pc         <= pc_inc;
                        if_valid   <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_valid  <= 1'b0;
                        pc        <= target;
                        imem_addr <= target;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end else if (id_ready) begin
                        if_valid  <= 1'b0;
                        imem_addr <= pc;
                        imem_req  <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        pending <= target;
                    end
                    if (ack) begin
                        pc        <= redirect ? target : pending;
                        imem_addr <= redirect ? target : pending;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
